// File: rtl/alu_control_md_if.sv
// Bus between main control and the ALU control / multiply-divide sequencer.
// Main control holds the master side; the decoder holds the slave side.
interface alu_control_md_if;
  logic [1:0] ALUOpValue;
  logic [5:0] funct;
  logic       instrValid;
  logic [3:0] ALUControlVal;
  logic       mdStart;
  logic [1:0] mdOp;
  logic       stall;
  logic       hiloWrite;
  logic [1:0] hiloRead;

  modport master (
    output ALUOpValue, funct, instrValid,
    input  ALUControlVal, mdStart, mdOp, stall, hiloWrite, hiloRead
  );

  modport slave (
    input  ALUOpValue, funct, instrValid,
    output ALUControlVal, mdStart, mdOp, stall, hiloWrite, hiloRead
  );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decoder with a sequencer for multi-cycle mult/multu/div/divu
// that starts the HI/LO unit, stalls the pipeline and strobes the HI/LO write.
module alu_control_md #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 16,
  parameter int CNT_WIDTH   = 5,
  parameter int ENABLE_MD   = 1
) (
  input logic clk,
  input logic reset,
  alu_control_md_if.slave bus
);

  localparam bit                   mdEnabled = (ENABLE_MD != 0);
  localparam logic [CNT_WIDTH-1:0] mulCount  = CNT_WIDTH'(MUL_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] divCount  = CNT_WIDTH'(DIV_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} stateType;

  stateType             state, nextState;
  logic [CNT_WIDTH-1:0] count, nextCount;
  logic [1:0]           mdOpReg, nextMdOp;
  logic                 postReset;
  logic                 isMD, isHiloFunct, isMdFunct;
  logic                 startC, stallC, writeC;
  logic [3:0]           aluCtrl;
  logic [1:0]           hiloRd;

  assign isMdFunct   = (bus.funct[5:2] == 4'b0110);
  assign isHiloFunct = (bus.funct == 6'b010000) || (bus.funct == 6'b010010);
  assign isMD        = mdEnabled && bus.instrValid && (bus.ALUOpValue == 2'b10) && isMdFunct;

  // Single-cycle decode, independent of the sequencer state.
  always_comb begin
    aluCtrl = 4'b0111;
    case (bus.ALUOpValue)
      2'b00: aluCtrl = 4'b0010;
      2'b01: aluCtrl = 4'b0110;
      2'b11: aluCtrl = 4'b1111;
      default: begin
        case (bus.funct)
          6'b100000: aluCtrl = 4'b0010;
          6'b100010: aluCtrl = 4'b0110;
          6'b100100: aluCtrl = 4'b0000;
          6'b100101: aluCtrl = 4'b0001;
          6'b000000: aluCtrl = 4'b0011;
          6'b100111: aluCtrl = 4'b1100;
          6'b101010: aluCtrl = 4'b0111;
          default:   aluCtrl = (mdEnabled && (isMdFunct || isHiloFunct)) ? 4'b1110 : 4'b0111;
        endcase
      end
    endcase
  end

  always_comb begin
    hiloRd = 2'b00;
    if (mdEnabled && bus.instrValid && (bus.ALUOpValue == 2'b10)) begin
      if (bus.funct == 6'b010000)      hiloRd = 2'b01;
      else if (bus.funct == 6'b010010) hiloRd = 2'b10;
    end
  end

  // Issue is suppressed in the cycle after reset so the strobes stay quiet
  // for two cycles; reset also masks every strobe in its own cycle.
  always_comb begin
    nextState = state;
    nextCount = count;
    nextMdOp  = mdOpReg;
    startC    = 1'b0;
    stallC    = 1'b0;
    writeC    = 1'b0;
    case (state)
      IDLE: begin
        if (isMD && !postReset) begin
          startC    = 1'b1;
          stallC    = 1'b1;
          nextState = BUSY;
          nextMdOp  = bus.funct[1:0];
          nextCount = bus.funct[1] ? divCount : mulCount;
        end
      end
      BUSY: begin
        if (count != '0) begin
          stallC    = 1'b1;
          nextCount = count - CNT_WIDTH'(1);
        end else begin
          writeC    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      startC = 1'b0;
      stallC = 1'b0;
      writeC = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      mdOpReg   <= 2'b00;
      postReset <= 1'b1;
    end else begin
      state     <= nextState;
      count     <= nextCount;
      mdOpReg   <= nextMdOp;
      postReset <= 1'b0;
    end
  end

  assign bus.ALUControlVal = aluCtrl;
  assign bus.hiloRead      = hiloRd;
  assign bus.mdStart       = startC;
  assign bus.stall         = stallC;
  assign bus.hiloWrite     = writeC;
  assign bus.mdOp          = mdOpReg;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: directed literal checks plus randomized traffic
// compared every cycle against a cycle-number based reference model.
module tb_alu_control_md;

  localparam int mulLat = 4;
  localparam int divLat = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_control_md_if busOn ();
  alu_control_md_if busOff ();

  assign busOff.ALUOpValue = busOn.ALUOpValue;
  assign busOff.funct      = busOn.funct;
  assign busOff.instrValid = busOn.instrValid;

  alu_control_md #(.MUL_LATENCY(mulLat), .DIV_LATENCY(divLat), .CNT_WIDTH(5), .ENABLE_MD(1))
    dutOn (.clk(clk), .reset(reset), .bus(busOn.slave));

  alu_control_md #(.MUL_LATENCY(mulLat), .DIV_LATENCY(divLat), .CNT_WIDTH(5), .ENABLE_MD(0))
    dutOff (.clk(clk), .reset(reset), .bus(busOff.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f, input logic v, input logic r);
    @(posedge clk);
    #1;
    busOn.ALUOpValue = op;
    busOn.funct      = f;
    busOn.instrValid = v;
    reset            = r;
  endtask

  function automatic logic [3:0] expAlu(input logic [1:0] op, input logic [5:0] f, input bit en);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b000000: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010:
        return en ? 4'b1110 : 4'b0111;
      default:   return 4'b0111;
    endcase
  endfunction

  function automatic logic [1:0] expHilo(input logic [1:0] op, input logic [5:0] f, input logic v, input bit en);
    if (!en || !v || op != 2'b10) return 2'b00;
    if (f == 6'b010000) return 2'b01;
    if (f == 6'b010010) return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: an in-flight op is described by the cycle number at
  // which it completes; stall and write follow from comparing against it.
  int         cyc = 0;
  int         doneCyc = 0;
  bit         inFlight = 1'b0;
  bit         prevReset = 1'b1;
  logic [1:0] expMdOp = 2'b00;
  bit         expIssue, expStall, expWrite, isMdNow;

  always @(negedge clk) begin
    expIssue = 1'b0;
    expStall = 1'b0;
    expWrite = 1'b0;
    isMdNow  = busOn.instrValid && (busOn.ALUOpValue == 2'b10) &&
               (busOn.funct >= 6'b011000) && (busOn.funct <= 6'b011011);
    if (!reset) begin
      if (inFlight) begin
        expStall = (cyc < doneCyc);
        expWrite = (cyc == doneCyc);
      end else if (isMdNow && !prevReset) begin
        expIssue = 1'b1;
        expStall = 1'b1;
      end
    end

    checkOutput("on.alu",   busOn.ALUControlVal, expAlu(busOn.ALUOpValue, busOn.funct, 1'b1));
    checkOutput("on.hilo",  busOn.hiloRead, expHilo(busOn.ALUOpValue, busOn.funct, busOn.instrValid, 1'b1));
    checkOutput("on.start", busOn.mdStart, expIssue);
    checkOutput("on.stall", busOn.stall, expStall);
    checkOutput("on.write", busOn.hiloWrite, expWrite);
    checkOutput("on.mdOp",  busOn.mdOp, expMdOp);
    checkOutput("off.alu",  busOff.ALUControlVal, expAlu(busOn.ALUOpValue, busOn.funct, 1'b0));
    checkOutput("off.hilo", busOff.hiloRead, 0);
    checkOutput("off.strobes", {busOff.mdStart, busOff.stall, busOff.hiloWrite}, 0);
    checkOutput("off.mdOp", busOff.mdOp, 0);

    if (reset) begin
      inFlight = 1'b0;
      expMdOp  = 2'b00;
    end else if (inFlight && cyc == doneCyc) begin
      inFlight = 1'b0;
    end else if (expIssue) begin
      inFlight = 1'b1;
      doneCyc  = cyc + (busOn.funct[1] ? divLat : mulLat);
      expMdOp  = busOn.funct[1:0];
    end
    prevReset = reset;
    cyc++;
  end

  logic [5:0] aluFuncts [6] = '{6'b100100, 6'b100101, 6'b000000, 6'b100111, 6'b101010, 6'b111111};
  logic [3:0] aluCodes  [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111, 4'b0111};
  logic [1:0] otherOps  [3] = '{2'b00, 2'b01, 2'b11};
  logic [3:0] otherCodes[3] = '{4'b0010, 4'b0110, 4'b1111};
  logic [5:0] functPool [12] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010,
                                 6'b100000, 6'b100010, 6'b100100, 6'b000000, 6'b101010, 6'b111111};
  logic       multStall [5] = '{1, 1, 1, 1, 0};
  logic       multWrite [5] = '{0, 0, 0, 0, 1};
  logic       multStart [5] = '{1, 0, 0, 0, 0};

  initial begin
    int stallCnt, startCnt, writeCnt, writeAt;
    reset            = 1'b1;
    busOn.ALUOpValue = 2'b00;
    busOn.funct      = 6'b000000;
    busOn.instrValid = 1'b0;
    applyStimulus(2'b00, 6'b000000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lit.resetStall", busOn.stall, 0);
    checkOutput("lit.resetMdOp", busOn.mdOp, 0);
    applyStimulus(2'b00, 6'b000000, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b10, aluFuncts[i], 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("lit.aluFunct", busOn.ALUControlVal, aluCodes[i]);
      checkOutput("lit.aluStall", busOn.stall, 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(otherOps[i], 6'b011000, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("lit.aluOp", busOn.ALUControlVal, otherCodes[i]);
    end

    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0 ? 2'b10 : 2'b00, 6'b011000, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("lit.multStart", busOn.mdStart, multStart[k]);
      checkOutput("lit.multStall", busOn.stall, multStall[k]);
      checkOutput("lit.multWrite", busOn.hiloWrite, multWrite[k]);
      checkOutput("lit.offAlu", busOff.ALUControlVal, k == 0 ? 4'b0111 : 4'b0010);
    end
    checkOutput("lit.multMdOp", busOn.mdOp, 0);

    stallCnt = 0; startCnt = 0; writeCnt = 0; writeAt = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0 ? 2'b10 : 2'b00, 6'b011011, 1'b1, 1'b0);
      @(negedge clk);
      stallCnt += int'(busOn.stall);
      startCnt += int'(busOn.mdStart);
      if (busOn.hiloWrite) begin
        writeCnt++;
        writeAt = k;
      end
    end
    checkOutput("lit.divuStalls", stallCnt, 16);
    checkOutput("lit.divuStarts", startCnt, 1);
    checkOutput("lit.divuWrites", writeCnt, 1);
    checkOutput("lit.divuWriteAt", writeAt, 16);
    checkOutput("lit.divuMdOp", busOn.mdOp, 3);

    for (int k = 0; k < 5; k++) applyStimulus(k == 0 ? 2'b10 : 2'b00, 6'b011010, 1'b1, 1'b0);
    applyStimulus(2'b00, 6'b000000, 1'b0, 1'b1);
    writeCnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(2'b00, 6'b000000, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 0) checkOutput("lit.abortStall", busOn.stall, 0);
      writeCnt += int'(busOn.hiloWrite);
    end
    checkOutput("lit.abortWrites", writeCnt, 0);
    checkOutput("lit.abortMdOp", busOn.mdOp, 0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b10, 6'b011001, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("lit.b2bWrite", busOn.hiloWrite, 1);
    applyStimulus(2'b10, 6'b010010, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lit.mfloRead", busOn.hiloRead, 2);
    checkOutput("lit.mfloAlu", busOn.ALUControlVal, 4'b1110);
    checkOutput("lit.mfloStall", busOn.stall, 0);
    checkOutput("lit.b2bMdOp", busOn.mdOp, 1);
    applyStimulus(2'b10, 6'b010000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lit.offMfhi", busOff.hiloRead, 0);
    checkOutput("lit.onMfhi", busOn.hiloRead, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [5:0] f;
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functPool[$urandom_range(0, 11)];
      applyStimulus(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b10, f,
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 79) == 0));
    end

    applyStimulus(2'b00, 6'b000000, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
Parametrised successor ALU control decoder for the MIPS datapath. Keeps single-cycle ALU control decode (ALUOp/funct -> 4-bit ALU control) and adds a sequencer for multi-cycle mult/multu/div/divu. The sequencer issues start to the HI/LO multiply-divide unit, stalls the PC/pipeline for a parametrised latency, and strobes the HI/LO write. Sits between main control and the ALU / HI/LO unit.

Parameters:
MUL_LATENCY, 4, stall cycles for mult/multu (>=2)
DIV_LATENCY, 16, stall cycles for div/divu (>=2)
CNT_WIDTH, 5, latency counter width; must hold max(MUL_LATENCY,DIV_LATENCY)-1
ENABLE_MD, 1, 1 = multi-cycle sequencer active; 0 = md functs decode as unknown, no stall/start/write ever

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
ALUOpValue  input  2  ALU op class from main control
funct  input  6  instruction funct field
instrValid  input  1  current instruction valid
ALUControlVal  output  4  ALU control code (combinational)
mdStart  output  1  one-cycle start pulse to HI/LO unit
mdOp  output  2  latched md op: 00 mult, 01 multu, 10 div, 11 divu
stall  output  1  freeze PC/instruction while high
hiloWrite  output  1  one-cycle HI/LO write strobe at completion
hiloRead  output  2  00 none, 01 mfhi, 10 mflo (combinational)

Behaviour:
- Reset: state IDLE, counter 0, mdOp 2'b00; mdStart, stall, hiloWrite 0 in the reset cycle and the cycle after.
- ALUControlVal decode (combinational, state-independent):
  - ALUOp 00 -> 0010; 01 -> 0110; 11 -> 1111.
  - ALUOp 10, by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 000000 -> 0011; 100111 -> 1100; 101010 -> 0111.
  - ALUOp 10 with md/mfhi/mflo functs (011000-011011, 010000, 010010) -> 1110 (ALU no-op), only when ENABLE_MD=1.
  - Any other funct -> 0111.
- hiloRead: 01 when ALUOp=10, funct=010000, instrValid; 10 for funct=010010; else 00; forced 00 if ENABLE_MD=0.
- isMD = ENABLE_MD && instrValid && ALUOp==10 && funct in {011000,011001,011010,011011}; mdOp code = funct[1:0].
- FSM states IDLE, BUSY:
  - IDLE & isMD: mdStart=1, stall=1 (combinational, same cycle). Next: BUSY, mdOp<=funct[1:0], counter<=LAT-1 (MUL_LATENCY for funct[1]=0, DIV_LATENCY for funct[1]=1).
  - IDLE & !isMD: all strobes 0.
  - BUSY & counter!=0: stall=1; counter decrements.
  - BUSY & counter==0: stall=0, hiloWrite=1; next IDLE.
- Timing: issue cycle + LAT-1 BUSY cycles stalled = LAT stall cycles. hiloWrite occurs in cycle LAT after issue; instruction retires that cycle.
- Inputs in BUSY are frozen by stall. Changes to ALUOp/funct/instrValid in BUSY do not affect the counter, mdOp or state; no re-issue.
- Back-to-back md: an md instruction presented in the cycle after hiloWrite issues normally (IDLE). There is no overlap.
- mdStart is never asserted in BUSY. hiloWrite is never asserted in IDLE.
- Reset mid-BUSY: next cycle IDLE, counter 0, mdOp 00. No hiloWrite for the aborted op.
- mdOp holds its value after completion until the next issue.

Test Plan:
- Reset then ALUOp=10 funct=100100/100101/000000/100111/101010/111111 -> ALUControlVal 0000/0001/0011/1100/0111/0111; ALUOp 00/01/11 -> 0010/0110/1111; stall=0 throughout.
- mult (funct 011000, instrValid=1) with defaults -> cycle0: mdStart=1, stall=1; cycles1-3: stall=1; cycle4: stall=0, hiloWrite=1; mdOp=00.
- divu (011011) -> stall high for 16 cycles; hiloWrite in cycle 16 only; mdOp=11; mdStart pulses once.
- reset asserted in cycle 5 of a div -> stall=0 next cycle; no hiloWrite in the following 20 cycles; mdOp=00.
- Back-to-back: multu directly followed by mflo -> mflo presented the cycle after hiloWrite gives hiloRead=10, ALUControlVal=1110, stall=0.
- ENABLE_MD=0: mult funct -> ALUControlVal=0111; mdStart, stall, hiloWrite stay 0; hiloRead=00 for 010000.
